// File: rtl/gmii_cut_through_router_pkg.sv
// Shared types and constants for the cut-through GMII router and its MAC lookup.
package gmii_router_definitions;

   localparam int NUM_PORTS_DEF   = 4;
   localparam int TABLE_DEPTH_DEF = 8;

   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic [7:0] data;
      logic       dv;
      logic       er;
   } gmii_interface;

   typedef logic [NUM_PORTS_DEF-1:0][TABLE_DEPTH_DEF-1:0][47:0] switch_table;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DA,
      ST_PAY,
      ST_DROP
   } parser_state_e;

endpackage

// File: rtl/gmii_cut_through_router_if.sv
// Ingress stream plus per-egress streams of one router instance.
interface gmii_cut_through_router_if
   import gmii_router_definitions::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF
) ();

   gmii_interface                 gmii_rx_in;
   gmii_interface [NUM_PORTS-1:0] gmii_tx_out;

   modport master (output gmii_rx_in, input gmii_tx_out);
   modport slave  (input gmii_rx_in, output gmii_tx_out);

endinterface

// File: rtl/gmii_cut_through_router_lookup.sv
// Registered MAC lookup: one cycle from request to egress port mask; never stalls.
// GMII_ROUTER_STATS_EN adds a saturating count of flood decisions.
module gmii_mac_lookup
   import gmii_router_definitions::*;
#(
   parameter int NUM_PORTS     = NUM_PORTS_DEF,
   parameter int TABLE_DEPTH   = TABLE_DEPTH_DEF,
   parameter int THIS_PORT     = 0,
   parameter int FLOOD_UNKNOWN = 1,
   parameter int FLOOD_MCAST   = 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_PORTS-1:0][TABLE_DEPTH-1:0][47:0] mac_table_i,
   input  logic                                        req_i,
   input  logic [47:0]                                 da_i,
   output logic                                        vld_o,
   output logic [NUM_PORTS-1:0]                        mask_o
`ifdef GMII_ROUTER_STATS_EN
   ,
   output logic [31:0]                                 stat_flood_o
`endif
);

   logic [NUM_PORTS-1:0][TABLE_DEPTH-1:0][47:0] table_q;
   logic [NUM_PORTS-1:0] hit, own, flood_mask, mask_d, mask_q;
   logic                 bcast_mc, miss, vld_q;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         for (int j = 0; j < TABLE_DEPTH; j++)
            if (table_q[i][j] == da_i && table_q[i][j] != '0)
               hit[i] = 1'b1;
      flood_mask            = '1;
      flood_mask[THIS_PORT] = 1'b0;
      own                   = hit;
      own[THIS_PORT]        = 1'b0;
      bcast_mc = (da_i == BCAST_MAC) || (FLOOD_MCAST != 0 && da_i[40]);
      // A hit only on our own port filters the frame rather than flooding it.
      miss     = (hit == '0);
      if (bcast_mc)
         mask_d = flood_mask;
      else if (miss)
         mask_d = (FLOOD_UNKNOWN != 0) ? flood_mask : '0;
      else
         mask_d = own;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         table_q <= '0;
         vld_q   <= 1'b0;
         mask_q  <= '0;
      end else begin
         table_q <= mac_table_i;
         vld_q   <= req_i;
         if (req_i)
            mask_q <= mask_d;
      end
   end

   assign vld_o  = vld_q;
   assign mask_o = mask_q;

`ifdef GMII_ROUTER_STATS_EN
   logic        flood_d;
   logic [31:0] flood_cnt_q;

   assign flood_d = bcast_mc || (miss && FLOOD_UNKNOWN != 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flood_cnt_q <= '0;
      else if (req_i && flood_d && flood_cnt_q != 32'hFFFF_FFFF)
         flood_cnt_q <= flood_cnt_q + 32'd1;
   end

   assign stat_flood_o = flood_cnt_q;
`endif

endmodule

// File: rtl/gmii_cut_through_router.sv
// Per-ingress cut-through GMII forwarder: fixed 17-cycle latency, no backpressure (stream cannot stall).
// GMII_ROUTER_STATS_EN adds stat_fwd/stat_drop/stat_flood saturating counters.
module gmii_cut_through_router
   import gmii_router_definitions::*;
#(
   parameter int NUM_PORTS     = NUM_PORTS_DEF,
   parameter int TABLE_DEPTH   = TABLE_DEPTH_DEF,
   parameter int THIS_PORT     = 0,
   parameter int MAX_PREAMBLE  = 7,
   parameter int FLOOD_UNKNOWN = 1,
   parameter int FLOOD_MCAST   = 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_PORTS-1:0][TABLE_DEPTH-1:0][47:0] mac_table,
   gmii_cut_through_router_if.slave                    gmii
`ifdef GMII_ROUTER_STATS_EN
   ,
   output logic [31:0]                                 stat_fwd,
   output logic [31:0]                                 stat_drop,
   output logic [31:0]                                 stat_flood
`endif
);

   localparam int         PIPE_DEPTH = 16;
   localparam logic [3:0] MAX_PRE    = 4'(MAX_PREAMBLE);

   gmii_interface                  rx;
   gmii_interface [PIPE_DEPTH-1:0] pipe_q;
   gmii_interface [NUM_PORTS-1:0]  tx_q;
   parser_state_e                  state_q;
   logic [3:0]                     pre_cnt_q;
   logic [2:0]                     da_cnt_q;
   logic [39:0]                    da_q;
   logic [47:0]                    da_full;
   logic                           lk_req, lk_vld, head, pending_valid_q;
   logic [NUM_PORTS-1:0]           lk_mask, pending_mask_q, active_mask_q, head_mask;

   assign rx        = gmii.gmii_rx_in;
   assign da_full   = {da_q, rx.data};
   assign lk_req    = (state_q == ST_DA) && rx.dv && (da_cnt_q == 3'd5);
   assign head      = pipe_q[PIPE_DEPTH-2].dv && !pipe_q[PIPE_DEPTH-1].dv;
   assign head_mask = pending_valid_q ? pending_mask_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= '0;
         da_cnt_q  <= '0;
         da_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE:
               if (rx.dv) begin
                  if (rx.data == PREAMBLE_BYTE) begin
                     state_q   <= ST_PRE;
                     pre_cnt_q <= 4'd1;
                  end else if (rx.data == SFD) begin
                     state_q  <= ST_DA;
                     da_cnt_q <= '0;
                  end else begin
                     state_q <= ST_DROP;
                  end
               end
            ST_PRE:
               if (!rx.dv)
                  state_q <= ST_IDLE;
               else if (rx.data == SFD) begin
                  state_q  <= ST_DA;
                  da_cnt_q <= '0;
               end else if (rx.data == PREAMBLE_BYTE && pre_cnt_q < MAX_PRE)
                  pre_cnt_q <= pre_cnt_q + 4'd1;
               else
                  state_q <= ST_DROP;
            ST_DA:
               if (!rx.dv)
                  state_q <= ST_IDLE;
               else begin
                  da_q <= da_full[39:0];
                  if (da_cnt_q == 3'd5)
                     state_q <= ST_PAY;
                  else
                     da_cnt_q <= da_cnt_q + 3'd1;
               end
            ST_PAY, ST_DROP:
               if (!rx.dv)
                  state_q <= ST_IDLE;
            default:
               state_q <= ST_IDLE;
         endcase
      end
   end

   gmii_mac_lookup #(
      .NUM_PORTS    (NUM_PORTS),
      .TABLE_DEPTH  (TABLE_DEPTH),
      .THIS_PORT    (THIS_PORT),
      .FLOOD_UNKNOWN(FLOOD_UNKNOWN),
      .FLOOD_MCAST  (FLOOD_MCAST)
   ) u_lookup (
      .clk         (clk),
      .rst         (rst),
      .mac_table_i (mac_table),
      .req_i       (lk_req),
      .da_i        (da_full),
      .vld_o       (lk_vld),
      .mask_o      (lk_mask)
`ifdef GMII_ROUTER_STATS_EN
      ,
      .stat_flood_o(stat_flood)
`endif
   );

   // The lookup lands at least one cycle before the frame head reaches the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q          <= '0;
         pending_mask_q  <= '0;
         pending_valid_q <= 1'b0;
         active_mask_q   <= '0;
         tx_q            <= '0;
      end else begin
         pipe_q <= {pipe_q[PIPE_DEPTH-2:0], rx};
         if (head) begin
            active_mask_q   <= head_mask;
            pending_valid_q <= 1'b0;
         end
         if (lk_vld) begin
            pending_mask_q  <= lk_mask;
            pending_valid_q <= 1'b1;
         end
         for (int i = 0; i < NUM_PORTS; i++)
            tx_q[i] <= (active_mask_q[i] && i != THIS_PORT) ? pipe_q[PIPE_DEPTH-1] : '0;
      end
   end

   assign gmii.gmii_tx_out = tx_q;

`ifdef GMII_ROUTER_STATS_EN
   logic [31:0] fwd_q, drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_q  <= '0;
         drop_q <= '0;
      end else if (head) begin
         if (head_mask != '0) begin
            if (fwd_q != 32'hFFFF_FFFF)
               fwd_q <= fwd_q + 32'd1;
         end else if (drop_q != 32'hFFFF_FFFF) begin
            drop_q <= drop_q + 32'd1;
         end
      end
   end

   assign stat_fwd  = fwd_q;
   assign stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_gmii_cut_through_router.sv
// Two routers (unknown-unicast flood on/off) share one ingress stream; a frame-level model predicts every egress byte.
module tb_gmii_cut_through_router;
   import gmii_router_definitions::*;

   localparam logic [47:0] DA_P1  = 48'h02_00_00_00_00_21;
   localparam logic [47:0] DA_P2  = 48'h02_00_00_00_00_11;
   localparam logic [47:0] DA_P3  = 48'h02_00_00_00_00_31;
   localparam logic [47:0] DA_OWN = 48'h02_00_00_00_00_01;
   localparam logic [47:0] DA_UNK = 48'h02_00_00_00_00_99;
   localparam logic [47:0] DA_MC  = 48'h01_00_5E_00_00_01;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   switch_table tbl;

   always #5 clk = ~clk;

   gmii_cut_through_router_if #(.NUM_PORTS(4)) bus1 ();
   gmii_cut_through_router_if #(.NUM_PORTS(4)) bus0 ();

`ifdef GMII_ROUTER_STATS_EN
   logic [31:0] fwd1, drop1, flood1, fwd0, drop0, flood0;
`endif

   gmii_cut_through_router #(.FLOOD_UNKNOWN(1)) dut_fu1 (
      .clk(clk), .rst(rst), .mac_table(tbl), .gmii(bus1)
`ifdef GMII_ROUTER_STATS_EN
      , .stat_fwd(fwd1), .stat_drop(drop1), .stat_flood(flood1)
`endif
   );

   gmii_cut_through_router #(.FLOOD_UNKNOWN(0)) dut_fu0 (
      .clk(clk), .rst(rst), .mac_table(tbl), .gmii(bus0)
`ifdef GMII_ROUTER_STATS_EN
      , .stat_fwd(fwd0), .stat_drop(drop0), .stat_flood(flood0)
`endif
   );

   int            total = 0;
   int            bad   = 0;
   int            m     = 0;
   int            lat_idx = -1;
   gmii_interface hist [4096];
   logic [3:0]    hm1  [4096];
   logic [3:0]    hm0  [4096];
   int            e_fwd1 = 0, e_drop1 = 0, e_flood1 = 0;
   int            e_fwd0 = 0, e_drop0 = 0, e_flood0 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
      end
   endtask

   // Ports whose table list contains the address; all-zero entries are empty.
   function automatic logic [3:0] ports_holding(input logic [47:0] da);
      logic [3:0] r = '0;
      for (int p = 0; p < 4; p++)
         for (int e = 0; e < 8; e++)
            if (da != '0 && tbl[p][e] == da) r[p] = 1'b1;
      return r;
   endfunction

   function automatic bit is_flood(input logic [47:0] da, input bit fu);
      return (da == BCAST_MAC) || da[40] || (ports_holding(da) == 4'b0 && fu);
   endfunction

   function automatic logic [3:0] route(input logic [47:0] da, input bit fu);
      if (is_flood(da, fu)) return 4'b1110;
      return ports_holding(da) & 4'b1110;
   endfunction

   function automatic logic [7:0] pay(input int i);
      logic [7:0] v = 8'(i * 37 + 17);
      if (v == 8'h55 || v == 8'hD5) v = v ^ 8'h01;
      return v;
   endfunction

   function automatic logic [39:0] expected_tx(input int k, input bit fu);
      logic [39:0] v = '0;
      logic [3:0]  mk;
      if (k < 0) return v;
      mk = fu ? hm1[k] : hm0[k];
      for (int p = 0; p < 4; p++)
         if (mk[p]) v[p*10 +: 10] = hist[k];
      return v;
   endfunction

   always @(negedge clk) begin
      int k;
      if (m > 0) begin
         k = m - 1 - 17;
         check("tx_flood_unknown", bus1.gmii_tx_out, expected_tx(k, 1'b1));
         check("tx_drop_unknown", bus0.gmii_tx_out, expected_tx(k, 1'b0));
         if (lat_idx >= 0 && m - 1 == lat_idx + 16)
            check("latency_not_early", bus1.gmii_tx_out[2], 64'h0);
         if (lat_idx >= 0 && m - 1 == lat_idx + 17)
            check("latency_head_p2", bus1.gmii_tx_out[2], {8'h55, 1'b1, 1'b0});
      end
   end

   task automatic drive_step(input logic [7:0] d, input logic dv, input logic er,
                             input logic [3:0] mk1, input logic [3:0] mk0);
      gmii_interface g;
      @(posedge clk);
      #1;
      rst = 1'b0;
      g.data = d;
      g.dv   = dv;
      g.er   = er;
      bus1.gmii_rx_in = g;
      bus0.gmii_rx_in = g;
      hist[m] = g;
      hm1[m]  = mk1;
      hm0[m]  = mk0;
      m++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_step(8'h00, 1'b0, 1'b0, 4'b0, 4'b0);
   endtask

   task automatic send_frame(input int npre, input logic [47:0] da, input int nda,
                             input int npay, input int er_at, input int rst_at);
      logic [7:0] b[$];
      logic [3:0] mk1, mk0;
      bit         valid, killed;
      for (int i = 0; i < npre; i++) b.push_back(8'h55);
      b.push_back(8'hD5);
      for (int i = 0; i < nda; i++) b.push_back(da[47-8*i -: 8]);
      for (int i = 0; i < npay; i++) b.push_back(pay(i));
      valid  = (npre <= 7) && (nda == 6);
      mk1    = valid ? route(da, 1'b1) : 4'b0;
      mk0    = valid ? route(da, 1'b0) : 4'b0;
      killed = 1'b0;
      for (int i = 0; i < b.size(); i++) begin
         drive_step(b[i], 1'b1, (i == er_at), killed ? 4'b0 : mk1, killed ? 4'b0 : mk0);
         if (i == rst_at) begin
            rst = 1'b1;
            for (int k = 0; k < m; k++) begin
               hm1[k] = 4'b0;
               hm0[k] = 4'b0;
            end
            killed = 1'b1;
            e_fwd1 = 0; e_drop1 = 0; e_flood1 = 0;
            e_fwd0 = 0; e_drop0 = 0; e_flood0 = 0;
         end
      end
      if (killed) begin
         e_drop1++;
         e_drop0++;
      end else begin
         if (mk1 != 4'b0) e_fwd1++; else e_drop1++;
         if (mk0 != 4'b0) e_fwd0++; else e_drop0++;
         if (valid && is_flood(da, 1'b1)) e_flood1++;
         if (valid && is_flood(da, 1'b0)) e_flood0++;
      end
   endtask

   initial begin
      gmii_interface z;
      z = '0;
      bus1.gmii_rx_in = z;
      bus0.gmii_rx_in = z;
      tbl = '0;
      tbl[2][3] = DA_P2;
      tbl[1][0] = DA_P1;
      tbl[3][5] = DA_P3;
      tbl[0][1] = DA_OWN;

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_fu1", bus1.gmii_tx_out, 64'h0);
      check("reset_tx_fu0", bus0.gmii_tx_out, 64'h0);
`ifdef GMII_ROUTER_STATS_EN
      check("reset_stat_fwd", fwd1, 64'h0);
      check("reset_stat_flood", flood1, 64'h0);
`endif

      check("model_known_p2", route(DA_P2, 1'b1), 64'h4);
      check("model_bcast", route(BCAST_MAC, 1'b0), 64'hE);
      check("model_unknown_drop", route(DA_UNK, 1'b0), 64'h0);
      check("model_unknown_flood", route(DA_UNK, 1'b1), 64'hE);
      check("model_own_port", route(DA_OWN, 1'b1), 64'h0);
      check("model_empty_entry", route(48'h0, 1'b0), 64'h0);

      idle(4);
      lat_idx = m;
      send_frame(7, DA_P2, 6, 50, 20, -1);
      idle(20);
      lat_idx = -1;
      send_frame(7, BCAST_MAC, 6, 50, -1, -1);
      idle(20);
      send_frame(7, DA_UNK, 6, 50, -1, -1);
      idle(20);
      send_frame(1, DA_P2, 3, 0, -1, -1);
      idle(2);
      send_frame(1, DA_P2, 6, 46, 30, -1);
      idle(20);
      send_frame(7, DA_P1, 6, 50, -1, -1);
      idle(1);
      send_frame(7, DA_P3, 6, 50, -1, -1);
      idle(20);
      send_frame(3, DA_OWN, 6, 40, -1, -1);
      idle(20);
      send_frame(7, DA_MC, 6, 40, -1, -1);
      idle(20);
      send_frame(2, 48'h0, 6, 40, -1, -1);
      idle(20);
      send_frame(8, DA_P2, 6, 40, -1, -1);
      idle(20);
      send_frame(7, DA_P3, 6, 50, -1, 30);
      idle(1);
      send_frame(7, DA_P1, 6, 50, -1, -1);
      idle(30);

`ifdef GMII_ROUTER_STATS_EN
      check("stat_fwd_fu1", fwd1, 64'(e_fwd1));
      check("stat_drop_fu1", drop1, 64'(e_drop1));
      check("stat_flood_fu1", flood1, 64'(e_flood1));
      check("stat_fwd_fu0", fwd0, 64'(e_fwd0));
      check("stat_drop_fu0", drop0, 64'(e_drop0));
      check("stat_flood_fu0", flood0, 64'(e_flood0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
